multi_key_debounce: RTL and testbench
=====================================

Name: multi_key_debounce

Overview:
- Parametrised N-channel successor to the single-key debouncer; sits between raw board keys/switches and game/audio control logic.
- Per channel: 2-FF synchroniser, stability counter, normalised pressed level, one-cycle press/release pulses, long-press detection.
- Optional auto-repeat for held keys (menu/score navigation).

Parameters:
- CHANNELS, 4, number of independent inputs (1..16).
- STABLE_CYCLES, 1024, cycles synchronised input must differ from the debounced level before it is accepted (>=2).
- LONG_CYCLES, 25000000, cycles of continuous press before long_pulse (0.5 s at 50 MHz; > STABLE_CYCLES).
- REPEAT_CYCLES, 5000000, auto-repeat period after a long press (used only with AUTOREPEAT_EN).
- ACTIVE_LOW, 1, 1 = raw input low means pressed (DE-board KEYs); 0 = high means pressed.

Ports:
- clk  in  1  system clock, 50 MHz
- resetN  in  1  asynchronous active-low reset
- button_in  in  CHANNELS  raw asynchronous inputs
- pressed  out  CHANNELS  debounced level, 1 = pressed, polarity normalised
- press_pulse  out  CHANNELS  one-cycle pulse on accepted press
- release_pulse  out  CHANNELS  one-cycle pulse on accepted release
- long_pulse  out  CHANNELS  one-cycle pulse when held LONG_CYCLES (and on each repeat if enabled)
- any_pressed  out  1  OR of pressed

Behaviour:
- Reset (async assert, sync deassert by flop design): sync flops load the idle raw level (1 if ACTIVE_LOW, else 0); counters 0; pressed, all pulses, any_pressed = 0; channel FSM = RELEASED.
- Synchroniser: s1 <= raw, s2 <= s1; candidate = s2 XOR ACTIVE_LOW.
- Stability counter (width $clog2(STABLE_CYCLES)): candidate == pressed -> clear to 0; else increment. When candidate != pressed and count == STABLE_CYCLES-1: next edge toggles pressed, clears counter, asserts press_pulse or release_pulse for exactly that one cycle (registered, coincident with the pressed change).
- Latency: clean step on button_in to pressed change = 2 + STABLE_CYCLES clocks (+ up to 1 for metastability sampling).
- Glitch shorter than STABLE_CYCLES: counter clears, no output change, no pulses.
- Hold FSM per channel: RELEASED -> PRESSED on accepted press (hold counter cleared). PRESSED: hold counter increments; at LONG_CYCLES-1 -> HELD with long_pulse for one cycle. HELD: counter frozen/saturated, no further pulses (without macro). Any state -> RELEASED on accepted release, same cycle as release_pulse; hold counter cleared.
- A release accepted in the same cycle the hold counter hits its terminal count: release wins, no long_pulse.
- Channels fully independent; simultaneous events on multiple channels all reported same cycle.
- any_pressed registered from next-state pressed vector, so it tracks pressed with zero skew.
- Reset mid-press: all outputs drop to 0 immediately; no release_pulse generated.

Optional Feature:
- Macro AUTOREPEAT_EN.
- Defined: HELD -> REPEAT; in REPEAT the hold counter reloads and each REPEAT_CYCLES cycles asserts long_pulse for one cycle until release.
- Undefined: no REPEAT state, REPEAT_CYCLES ignored, single long_pulse per press; no repeat counter logic synthesised.

Decomposition:
- Package debounce_pkg: enum hold_state_t {RELEASED, PRESSED, HELD, REPEAT}; constant MAX_CHANNELS = 16; width helper constants.
- Sub-module debounce_channel (one synchroniser, stability counter, hold FSM), instantiated CHANNELS times in a generate loop; top does only polarity parameter pass-through and any_pressed reduction.

Test Plan (CHANNELS=2, STABLE_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=16, ACTIVE_LOW=1):
- Reset held, button_in=2'b11 -> all outputs 0; release resetN, hold 50 cycles -> outputs stay 0.
- ch0 driven low and held -> pressed[0]=1 and press_pulse[0] high for one cycle exactly 10 cycles after the step; ch1 unaffected.
- ch0 low pulses of 5 cycles repeated with 3-cycle gaps -> pressed[0] never rises, no pulses.
- ch0 held low 60 cycles -> long_pulse[0] once, 32 cycles after press_pulse; release -> release_pulse[0] 10 cycles after rising edge; with AUTOREPEAT_EN further long_pulse every 16 cycles until release.
- Both channels pressed same cycle -> simultaneous press_pulse=2'b11, any_pressed=1; release ch1 only -> any_pressed stays 1.
- resetN asserted while ch0 pressed and hold count=20 -> pressed, any_pressed drop asynchronously; no release_pulse; after deassert with ch0 still low -> new press_pulse after 10 cycles.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the multi-channel key debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2,
    REPEAT   = 2'd3
  } hold_state_t;

  localparam int MAX_CHANNELS = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-FF synchroniser, stability counter and hold/long-press FSM.
// Macro AUTOREPEAT_EN adds periodic long_pulse while the key stays held.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic resetN,
  input  logic button_in,
  output logic pressed,
  output logic pressed_next,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int STAB_W = cnt_width(STABLE_CYCLES);
  // One counter serves both the long-press and the repeat interval.
  localparam int HOLD_W = cnt_width((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
`endif

  logic s1_q, s1_d, s2_q, s2_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic pressed_q, pressed_d;
  logic press_pulse_q, press_pulse_d;
  logic release_pulse_q, release_pulse_d;
  logic long_pulse_q, long_pulse_d;
  hold_state_t state_q, state_d;
  logic candidate, accept;

  always_comb begin
    s1_d            = button_in;
    s2_d            = s1_q;
    candidate       = s2_q ^ ACTIVE_LOW;
    accept          = (candidate != pressed_q) && (stab_cnt_q == STAB_LAST);
    stab_cnt_d      = (candidate == pressed_q || accept) ? '0 : stab_cnt_q + STAB_W'(1);
    pressed_d       = pressed_q ^ accept;
    press_pulse_d   = accept & ~pressed_q;
    release_pulse_d = accept & pressed_q;

    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    long_pulse_d = 1'b0;
    // Release takes priority, so a release on the terminal count suppresses long_pulse.
    if (release_pulse_d) begin
      state_d    = RELEASED;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        RELEASED: begin
          if (press_pulse_d) begin
            state_d    = PRESSED;
            hold_cnt_d = '0;
          end
        end
        PRESSED: begin
          if (hold_cnt_q == LONG_LAST) begin
            state_d      = HELD;
            long_pulse_d = 1'b1;
`ifdef AUTOREPEAT_EN
            hold_cnt_d   = '0;
`endif
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
`ifdef AUTOREPEAT_EN
        HELD: begin
          state_d    = REPEAT;
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        REPEAT: begin
          if (hold_cnt_q == REPEAT_LAST) begin
            long_pulse_d = 1'b1;
            hold_cnt_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
`else
        HELD: begin
          state_d = HELD;
        end
`endif
        default: state_d = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_q            <= ACTIVE_LOW;
      s2_q            <= ACTIVE_LOW;
      stab_cnt_q      <= '0;
      hold_cnt_q      <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      state_q         <= RELEASED;
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      stab_cnt_q      <= stab_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      state_q         <= state_d;
    end
  end

  assign pressed       = pressed_q;
  assign pressed_next  = pressed_d;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;

endmodule

// File: rtl/multi_key_debounce.sv
// N independent debounced keys with press/release/long-press pulses.
// Auto-repeat of long_pulse is enabled by defining AUTOREPEAT_EN.
module multi_key_debounce
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1024,
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic                any_pressed
);

  logic [CHANNELS-1:0] pressed_next;
  logic any_pressed_q, any_pressed_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk          (clk),
      .resetN       (resetN),
      .button_in    (button_in[i]),
      .pressed      (pressed[i]),
      .pressed_next (pressed_next[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

  // Built from next-state levels so it changes on the same edge as pressed.
  assign any_pressed_d = |pressed_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) any_pressed_q <= 1'b0;
    else         any_pressed_q <= any_pressed_d;
  end

  assign any_pressed = any_pressed_q;

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed bench for multi_key_debounce (2 channels, short timing constants).
module tb_multi_key_debounce;

  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          resetN;
  logic [CH-1:0] button_in;
  logic [CH-1:0] pressed, press_pulse, release_pulse, long_pulse;
  logic          any_pressed;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multi_key_debounce #(
    .CHANNELS     (CH),
    .STABLE_CYCLES(8),
    .LONG_CYCLES  (32),
    .REPEAT_CYCLES(16),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .button_in    (button_in),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .any_pressed  (any_pressed)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [8:0] seen;
    tick(3);
    n_checks++;
    if ({pressed, press_pulse, release_pulse, long_pulse, any_pressed} !== 9'b0)
      $display("FAIL reset_hold: got %b expected 0", {pressed, press_pulse, release_pulse, long_pulse, any_pressed});
    else n_pass++;
    resetN = 1'b1;
    seen = '0;
    for (int k = 1; k <= 50; k++) begin
      tick(1);
      seen |= {pressed, press_pulse, release_pulse, long_pulse, any_pressed};
    end
    n_checks++;
    if (seen !== 9'b0) $display("FAIL idle_after_reset: got %b expected 0", seen);
    else n_pass++;
  endtask

  task automatic test_press;
    button_in[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 9) begin
        n_checks++;
        if (pressed !== 2'b00) $display("FAIL press_early: got %b expected 00", pressed);
        else n_pass++;
      end
      if (k == 10) begin
        n_checks++;
        if ({pressed, press_pulse, any_pressed} !== 5'b01_01_1)
          $display("FAIL press_at_10: got %b expected 01011", {pressed, press_pulse, any_pressed});
        else n_pass++;
      end
      if (k == 11) begin
        n_checks++;
        if ({pressed, press_pulse} !== 4'b01_00)
          $display("FAIL press_pulse_width: got %b expected 0100", {pressed, press_pulse});
        else n_pass++;
      end
    end
    button_in[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 10) begin
        n_checks++;
        if ({pressed, release_pulse, any_pressed} !== 5'b00_01_0)
          $display("FAIL release_at_10: got %b expected 00010", {pressed, release_pulse, any_pressed});
        else n_pass++;
      end
    end
  endtask

  task automatic test_glitch;
    logic [3:0] seen;
    seen = '0;
    for (int r = 0; r < 4; r++) begin
      button_in[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick(1);
        seen |= {pressed[0], press_pulse[0], release_pulse[0], long_pulse[0]};
      end
      button_in[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        seen |= {pressed[0], press_pulse[0], release_pulse[0], long_pulse[0]};
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(1);
      seen |= {pressed[0], press_pulse[0], release_pulse[0], long_pulse[0]};
    end
    n_checks++;
    if (seen !== 4'b0) $display("FAIL glitch_rejected: got %b expected 0000", seen);
    else n_pass++;
  endtask

  task automatic test_long;
    int pp_at, rp_at, first_lp, second_lp, n_long;
    int exp_n_long, exp_second;
`ifdef AUTOREPEAT_EN
    exp_n_long = 2;
    exp_second = 58;
`else
    exp_n_long = 1;
    exp_second = 0;
`endif
    pp_at = 0; rp_at = 0; first_lp = 0; second_lp = 0; n_long = 0;
    button_in[0] = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick(1);
      if (press_pulse[0] && pp_at == 0) pp_at = k;
      if (release_pulse[0] && rp_at == 0) rp_at = k;
      if (long_pulse[0]) begin
        n_long++;
        if (first_lp == 0) first_lp = k;
        else if (second_lp == 0) second_lp = k;
      end
      if (k == 60) button_in[0] = 1'b1;
    end
    n_checks++;
    if (pp_at !== 10) $display("FAIL long_press_at: got %0d expected 10", pp_at);
    else n_pass++;
    n_checks++;
    if (first_lp !== 42) $display("FAIL long_first_at: got %0d expected 42", first_lp);
    else n_pass++;
    n_checks++;
    if (n_long !== exp_n_long) $display("FAIL long_count: got %0d expected %0d", n_long, exp_n_long);
    else n_pass++;
    n_checks++;
    if (second_lp !== exp_second) $display("FAIL long_second_at: got %0d expected %0d", second_lp, exp_second);
    else n_pass++;
    n_checks++;
    if (rp_at !== 70) $display("FAIL long_release_at: got %0d expected 70", rp_at);
    else n_pass++;
    n_checks++;
    if ({pressed, any_pressed} !== 3'b000) $display("FAIL long_final: got %b expected 000", {pressed, any_pressed});
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    logic any_low;
    button_in = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 10) begin
        n_checks++;
        if ({pressed, press_pulse, any_pressed} !== 5'b11_11_1)
          $display("FAIL both_press: got %b expected 11111", {pressed, press_pulse, any_pressed});
        else n_pass++;
      end
    end
    button_in[1] = 1'b1;
    any_low = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      any_low |= ~any_pressed;
      if (k == 10) begin
        n_checks++;
        if ({pressed, release_pulse} !== 4'b01_10)
          $display("FAIL ch1_release: got %b expected 0110", {pressed, release_pulse});
        else n_pass++;
      end
    end
    n_checks++;
    if (any_low !== 1'b0) $display("FAIL any_held: got dropped=%b expected 0", any_low);
    else n_pass++;
    button_in[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 9) begin
        n_checks++;
        if ({pressed, any_pressed} !== 3'b01_1)
          $display("FAIL any_before_release: got %b expected 011", {pressed, any_pressed});
        else n_pass++;
      end
      if (k == 10) begin
        n_checks++;
        if ({pressed, release_pulse, any_pressed} !== 5'b00_01_0)
          $display("FAIL any_zero_skew: got %b expected 00010", {pressed, release_pulse, any_pressed});
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_press;
    logic [CH-1:0] rp_seen;
    rp_seen = '0;
    button_in[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 30) begin
        n_checks++;
        if ({pressed, any_pressed} !== 3'b01_1)
          $display("FAIL pre_reset_pressed: got %b expected 011", {pressed, any_pressed});
        else n_pass++;
      end
    end
    #2 resetN = 1'b0;
    #1;
    n_checks++;
    if ({pressed, press_pulse, release_pulse, long_pulse, any_pressed} !== 9'b0)
      $display("FAIL async_reset_drop: got %b expected 0", {pressed, press_pulse, release_pulse, long_pulse, any_pressed});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      rp_seen |= release_pulse;
    end
    resetN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      rp_seen |= release_pulse;
      if (k == 9) begin
        n_checks++;
        if ({pressed, press_pulse} !== 4'b00_00)
          $display("FAIL repress_early: got %b expected 0000", {pressed, press_pulse});
        else n_pass++;
      end
      if (k == 10) begin
        n_checks++;
        if ({pressed, press_pulse, any_pressed} !== 5'b01_01_1)
          $display("FAIL repress_at_10: got %b expected 01011", {pressed, press_pulse, any_pressed});
        else n_pass++;
      end
    end
    n_checks++;
    if (rp_seen !== 2'b00) $display("FAIL no_release_on_reset: got %b expected 00", rp_seen);
    else n_pass++;
  endtask

  initial begin
    resetN    = 1'b0;
    button_in = 2'b11;
    test_reset;
    test_press;
    test_glitch;
    test_long;
    test_simultaneous;
    test_reset_mid_press;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
